// File: rtl/crb_host_if.sv
// Host access bus for the CRB control area and data buffer.
//   host_addr  : byte address; bit12=1 selects the data buffer, 0 the registers
//   host_wr    : one-cycle write strobe
//   host_rd    : one-cycle read strobe
//   host_wdata : write data
//   host_loc   : locality issuing this access
//   host_rdata : read data, valid while host_ack is high
//   host_ack   : one-cycle acknowledge, the cycle after any strobe
interface crb_host_if;
    logic [12:0] host_addr;
    logic        host_wr;
    logic        host_rd;
    logic [7:0]  host_wdata;
    logic [2:0]  host_loc;
    logic [7:0]  host_rdata;
    logic        host_ack;

    modport master (
        output host_addr, host_wr, host_rd, host_wdata, host_loc,
        input  host_rdata, host_ack
    );

    modport slave (
        input  host_addr, host_wr, host_rd, host_wdata, host_loc,
        output host_rdata, host_ack
    );
endinterface

// File: rtl/crb_host_regs.sv
// CRB host register block and shared command/response buffer.
// Decodes byte-wide host accesses, tracks locality ownership, runs the
// idle/ready/start/complete protocol and launches the transfer engine.
//   clock, reset_n    : clock, asynchronous active-low reset
//   host              : host access bus (crb_host_if.slave)
//   locality          : granted locality, 8'hFF when none
//   cmdAbort          : cancel level to the engine while a command is in flight
//   cmdSize           : latched CMD_SIZE
//   cmdSend           : one-cycle engine start pulse
//   cmdOutAddr        : engine command read address
//   cmdByteIn         : buffer[cmdOutAddr], one cycle later
//   rspSize           : response length from the engine
//   rspSend           : active-low response byte write strobe
//   rspOutAddr        : response byte address
//   rspByteOut        : response byte
//   cmdDone, rspDone  : engine phase completion
//   rsp_irq           : one-cycle pulse on entry to DONE
module crb_host_regs #(
    parameter int BUF_AW  = 12,
    parameter int NUM_LOC = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    crb_host_if.slave         host,
    output logic [7:0]        locality,
    output logic              cmdAbort,
    output logic [31:0]       cmdSize,
    output logic              cmdSend,
    input  logic [BUF_AW-1:0] cmdOutAddr,
    output logic [7:0]        cmdByteIn,
    input  logic [31:0]       rspSize,
    input  logic              rspSend,
    input  logic [BUF_AW-1:0] rspOutAddr,
    input  logic [7:0]        rspByteOut,
    input  logic              cmdDone,
    input  logic              rspDone,
    output logic              rsp_irq
);
    typedef enum logic [2:0] {
        S_IDLE, S_READY, S_START, S_BUSY_CMD, S_BUSY_EXEC, S_BUSY_RSP, S_DONE
    } state_e;

    localparam logic [7:0] LOC_NONE  = 8'hFF;
    localparam logic [3:0] NUM_LOC_L = 4'(NUM_LOC);

    state_e      state_q, state_d;
    logic [7:0]  loc_q;
    logic        cancel_q;
    logic        error_q;
    logic [31:0] cmd_size_q;
    logic [31:0] rsp_size_q;
    logic [7:0]  rdata_q, rdata_d;
    logic        ack_q;
    logic        irq_q;
    logic [7:0]  cmd_byte_q;
    logic [7:0]  mem_q [0:(1<<BUF_AW)-1];

    logic        is_buf;
    logic [11:0] reg_off;
    logic        rd_en;
    logic        owner;
    logic        reg_wr;
    logic        loc_ctrl_wr;
    logic        cmd_ready;
    logic        go_idle;
    logic        start_wr;
    logic        cancel_wr;
    logic        size_wr;
    logic        busy;
    logic        buf_open;
    logic        host_buf_wr;
    logic        eng_wr;
    logic        size_err;
    logic        enter_ready;
    logic        enter_done;

    assign is_buf  = host.host_addr[12];
    assign reg_off = host.host_addr[11:0];
    // A simultaneous write wins; the read half is discarded.
    assign rd_en   = host.host_rd & ~host.host_wr;
    // loc_q is 8'hFF when free, so this can never match with no owner.
    assign owner   = (loc_q == {5'd0, host.host_loc});
    assign reg_wr  = host.host_wr & ~is_buf & owner;

    // LOC_CTRL is the one register a non-owner may write.
    assign loc_ctrl_wr = host.host_wr & ~is_buf & (reg_off == 12'h008);
    assign cmd_ready   = reg_wr & (reg_off == 12'h040) & host.host_wdata[0];
    assign go_idle     = reg_wr & (reg_off == 12'h040) & host.host_wdata[1];
    assign start_wr    = reg_wr & (reg_off == 12'h04C) & host.host_wdata[0];
    assign cancel_wr   = reg_wr & (reg_off == 12'h048);
    assign size_wr     = reg_wr & (reg_off[11:2] == 10'h016) & (state_q == S_READY);

    assign busy     = (state_q == S_START) || (state_q == S_BUSY_CMD) ||
                      (state_q == S_BUSY_EXEC) || (state_q == S_BUSY_RSP);
    assign buf_open = (state_q == S_READY) || (state_q == S_DONE);

    assign host_buf_wr = host.host_wr & is_buf & owner & buf_open;
    // The engine also pulses rspSend during command ingest; only the
    // response phases may write the buffer.
    assign eng_wr = ~rspSend & ((state_q == S_BUSY_EXEC) || (state_q == S_BUSY_RSP));

    assign size_err = (cmd_size_q >> BUF_AW) != 32'd0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (cmd_ready) state_d = S_READY;
            S_READY: begin
                if (go_idle)       state_d = S_IDLE;
                else if (start_wr) state_d = S_START;
            end
            S_START:     state_d = size_err ? S_DONE : S_BUSY_CMD;
            S_BUSY_CMD:  if (cmdDone) state_d = S_BUSY_EXEC;
            S_BUSY_EXEC: begin
                if (rspDone)       state_d = S_DONE;
                else if (!rspSend) state_d = S_BUSY_RSP;
            end
            S_BUSY_RSP:  if (rspDone) state_d = S_DONE;
            S_DONE: begin
                if (go_idle)        state_d = S_IDLE;
                else if (cmd_ready) state_d = S_READY;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    assign enter_ready = (state_d == S_READY) && (state_q != S_READY);
    assign enter_done  = (state_d == S_DONE) && (state_q != S_DONE);

    always_comb begin
        rdata_d = 8'h00;
        if (rd_en) begin
            if (is_buf) begin
                rdata_d = buf_open ? mem_q[host.host_addr[BUF_AW-1:0]] : 8'hFF;
            end else begin
                case (reg_off)
                    12'h000: rdata_d = (loc_q == LOC_NONE) ? 8'h00 : {5'b10000, loc_q[2:0]};
                    12'h044: rdata_d = {6'd0, state_q == S_IDLE, error_q};
                    12'h048: rdata_d = {7'd0, cancel_q};
                    12'h04C: rdata_d = {7'd0, busy};
                    12'h058: rdata_d = cmd_size_q[7:0];
                    12'h059: rdata_d = cmd_size_q[15:8];
                    12'h05A: rdata_d = cmd_size_q[23:16];
                    12'h05B: rdata_d = cmd_size_q[31:24];
                    12'h064: rdata_d = rsp_size_q[7:0];
                    12'h065: rdata_d = rsp_size_q[15:8];
                    12'h066: rdata_d = rsp_size_q[23:16];
                    12'h067: rdata_d = rsp_size_q[31:24];
                    default: rdata_d = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            loc_q      <= LOC_NONE;
            cancel_q   <= 1'b0;
            error_q    <= 1'b0;
            cmd_size_q <= 32'd0;
            rsp_size_q <= 32'd0;
            rdata_q    <= 8'h00;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
            cmd_byte_q <= 8'hFF;
        end else begin
            state_q    <= state_d;
            ack_q      <= host.host_wr | host.host_rd;
            rdata_q    <= rdata_d;
            irq_q      <= enter_done;
            cmd_byte_q <= mem_q[cmdOutAddr];

            if (loc_ctrl_wr) begin
                if (host.host_wdata[0] && (loc_q == LOC_NONE) && ({1'b0, host.host_loc} < NUM_LOC_L))
                    loc_q <= {5'd0, host.host_loc};
                else if (host.host_wdata[1] && owner && ((state_q == S_IDLE) || (state_q == S_READY)))
                    loc_q <= LOC_NONE;
            end

            if (enter_ready)    cancel_q <= 1'b0;
            else if (cancel_wr) cancel_q <= host.host_wdata[0];

            // error describes the last command only; a new cmdReady clears it.
            if (enter_ready)
                error_q <= 1'b0;
            else if ((state_q == S_START) && size_err)
                error_q <= 1'b1;
            else if (cmdAbort && rspDone && ((state_q == S_BUSY_EXEC) || (state_q == S_BUSY_RSP)))
                error_q <= 1'b1;

            if (size_wr)
                cmd_size_q[{reg_off[1:0], 3'b000} +: 8] <= host.host_wdata;

            // An oversize command reaches DONE straight from START with no response.
            if (enter_done)
                rsp_size_q <= (state_q == S_START) ? 32'd0 : rspSize;
        end
    end

    // Buffer storage is not reset. Engine write has priority; the host
    // side is closed whenever the engine can write, so they never collide.
    always_ff @(posedge clock) begin
        if (eng_wr)
            mem_q[rspOutAddr] <= rspByteOut;
        else if (host_buf_wr)
            mem_q[host.host_addr[BUF_AW-1:0]] <= host.host_wdata;
    end

    assign locality        = loc_q;
    assign cmdAbort        = cancel_q & busy;
    assign cmdSize         = cmd_size_q;
    assign cmdSend         = (state_q == S_START) && !size_err;
    assign cmdByteIn       = cmd_byte_q;
    assign rsp_irq         = irq_q;
    assign host.host_rdata = rdata_q;
    assign host.host_ack   = ack_q;
endmodule

// File: tb/tb_crb_host_regs.sv
module tb_crb_host_regs;
    localparam int BUF_AW  = 12;
    localparam int NUM_LOC = 5;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  locality;
    logic        cmdAbort;
    logic [31:0] cmdSize;
    logic        cmdSend;
    logic [11:0] cmdOutAddr;
    logic [7:0]  cmdByteIn;
    logic [31:0] rspSize;
    logic        rspSend;
    logic [11:0] rspOutAddr;
    logic [7:0]  rspByteOut;
    logic        cmdDone;
    logic        rspDone;
    logic        rsp_irq;

    crb_host_if hif();

    crb_host_regs #(.BUF_AW(BUF_AW), .NUM_LOC(NUM_LOC)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .host       (hif),
        .locality   (locality),
        .cmdAbort   (cmdAbort),
        .cmdSize    (cmdSize),
        .cmdSend    (cmdSend),
        .cmdOutAddr (cmdOutAddr),
        .cmdByteIn  (cmdByteIn),
        .rspSize    (rspSize),
        .rspSend    (rspSend),
        .rspOutAddr (rspOutAddr),
        .rspByteOut (rspByteOut),
        .cmdDone    (cmdDone),
        .rspDone    (rspDone),
        .rsp_irq    (rsp_irq)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int send_cnt = 0;
    int irq_cnt = 0;

    // Pulse counters sampled at the active edge, before the DUT updates.
    always @(posedge clock) begin
        if (cmdSend === 1'b1) send_cnt++;
        if (rsp_irq === 1'b1) irq_cnt++;
    end

    // Reference model: what software should observe, by protocol phase.
    logic [7:0]  mdl_mem [0:(1<<BUF_AW)-1];
    int          mdl_owner = -1;
    bit          mdl_idle = 1'b1;
    bit          mdl_open = 1'b0;
    bit          mdl_busy = 1'b0;
    bit          mdl_err = 1'b0;
    bit          mdl_cancel = 1'b0;
    logic [31:0] mdl_cmd_size = 32'd0;
    logic [31:0] mdl_rsp_size = 32'd0;
    logic [7:0]  fix_rsp [10] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [11:0] mapped [8] = '{12'h000, 12'h044, 12'h048, 12'h04C, 12'h058, 12'h05A, 12'h064, 12'h065};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_reg(input logic [11:0] off);
        logic [7:0] v;
        v = 8'h00;
        case (off)
            12'h000: if (mdl_owner >= 0) v = 8'h80 | 8'(mdl_owner);
            12'h044: v = {6'd0, mdl_idle, mdl_err};
            12'h048: v = {7'd0, mdl_cancel};
            12'h04C: v = {7'd0, mdl_busy};
            12'h058, 12'h059, 12'h05A, 12'h05B: v = 8'(mdl_cmd_size >> (8 * int'(off[1:0])));
            12'h064, 12'h065, 12'h066, 12'h067: v = 8'(mdl_rsp_size >> (8 * int'(off[1:0])));
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bus(input logic [12:0] a, input bit w, input bit r, input logic [7:0] d,
                       input logic [2:0] l, output logic [7:0] rd, output logic ak);
        @(negedge clock);
        hif.host_addr = a; hif.host_wr = w; hif.host_rd = r; hif.host_wdata = d; hif.host_loc = l;
        @(negedge clock);
        hif.host_wr = 1'b0; hif.host_rd = 1'b0;
        rd = hif.host_rdata;
        ak = hif.host_ack;
    endtask

    task automatic wr(input logic [12:0] a, input logic [7:0] d, input logic [2:0] l);
        logic [7:0] rd;
        logic ak;
        bus(a, 1'b1, 1'b0, d, l, rd, ak);
        chk("wr_ack", 32'(ak), 32'd1);
    endtask

    task automatic rdc(input string tag, input logic [12:0] a, input logic [2:0] l, input logic [7:0] exp);
        logic [7:0] rd;
        logic ak;
        bus(a, 1'b0, 1'b1, 8'h00, l, rd, ak);
        chk(tag, 32'(rd), 32'(exp));
    endtask

    task automatic rdbuf(input string tag, input int i);
        rdc(tag, 13'h1000 | 13'(i), 3'd0, mdl_open ? mdl_mem[i] : 8'hFF);
    endtask

    task automatic eng_rsp_byte(input logic [11:0] a, input logic [7:0] d);
        @(negedge clock);
        rspSend = 1'b0; rspOutAddr = a; rspByteOut = d;
        @(negedge clock);
        rspSend = 1'b1;
    endtask

    task automatic eng_cmd_done();
        @(negedge clock); cmdDone = 1'b1;
        @(negedge clock); cmdDone = 1'b0;
    endtask

    task automatic eng_rsp_done(input logic [31:0] sz);
        @(negedge clock); rspSize = sz; rspDone = 1'b1;
        @(negedge clock); rspDone = 1'b0;
    endtask

    task automatic set_size(input logic [31:0] sz);
        for (int j = 0; j < 4; j++) wr(13'h058 + 13'(j), 8'(sz >> (8 * j)), 3'd0);
    endtask

    // One full command from READY to DONE, owned by locality 0.
    task automatic run_cmd(input int n, input int r, input bit cancel, input bit fixed);
        logic [7:0] b, rd;
        logic ak;
        int a, s0, i0;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            wr(13'h1000 + 13'(i), b, 3'd0);
            mdl_mem[i] = b;
        end
        rdbuf("cmd_readback", $urandom_range(0, n - 1));
        set_size(32'(n));
        mdl_cmd_size = 32'(n);
        chk("cmdSize", cmdSize, mdl_cmd_size);

        s0 = send_cnt;
        wr(13'h04C, 8'h01, 3'd2);
        cycles(3);
        chk("start_nonowner_send", 32'(send_cnt - s0), 32'd0);
        rdc("start_nonowner_rd", 13'h04C, 3'd0, exp_reg(12'h04C));

        s0 = send_cnt;
        wr(13'h04C, 8'h01, 3'd0);
        mdl_busy = 1'b1; mdl_open = 1'b0;
        cycles(3);
        chk("send_once", 32'(send_cnt - s0), 32'd1);
        rdc("start_busy_rd", 13'h04C, 3'd0, exp_reg(12'h04C));

        for (int t = 0; t < 4; t++) begin
            a = $urandom_range(0, n - 1);
            @(negedge clock); cmdOutAddr = 12'(a);
            @(negedge clock); chk("cmdByteIn", 32'(cmdByteIn), 32'(mdl_mem[a]));
        end

        eng_rsp_byte(12'($urandom_range(r, n - 1)), 8'($urandom));
        wr(13'h1000 + 13'(n - 1), ~mdl_mem[n - 1], 3'd0);
        bus(13'h1000 + 13'(n - 1), 1'b0, 1'b1, 8'h00, 3'd0, rd, ak);
        chk("busy_rd_data", 32'(rd), 32'h0FF);
        chk("busy_rd_ack", 32'(ak), 32'd1);
        chk("abort_no_cancel", 32'(cmdAbort), 32'd0);

        eng_cmd_done();
        if (cancel) begin
            wr(13'h048, 8'h01, 3'd0);
            mdl_cancel = 1'b1;
            chk("abort_on", 32'(cmdAbort), 32'd1);
        end
        for (int i = 0; i < r; i++) begin
            b = fixed ? fix_rsp[i] : 8'($urandom);
            eng_rsp_byte(12'(i), b);
            mdl_mem[i] = b;
        end
        if (cancel) chk("abort_held", 32'(cmdAbort), 32'd1);

        i0 = irq_cnt;
        eng_rsp_done(32'(r));
        mdl_busy = 1'b0; mdl_open = 1'b1; mdl_rsp_size = 32'(r);
        if (cancel) mdl_err = 1'b1;
        cycles(3);
        chk("irq_once", 32'(irq_cnt - i0), 32'd1);
        chk("abort_done", 32'(cmdAbort), 32'd0);
        for (int j = 0; j < 4; j++) rdc("rsp_size", 13'h064 + 13'(j), 3'd0, exp_reg(12'h064 + 12'(j)));
        rdc("start_cleared", 13'h04C, 3'd0, exp_reg(12'h04C));
        rdc("sts_done", 13'h044, 3'd0, exp_reg(12'h044));
        rdc("cancel_done", 13'h048, 3'd0, exp_reg(12'h048));
        for (int i = 0; i < n; i++) rdbuf("buf_after", i);
    endtask

    task automatic cmd_ready_owner();
        wr(13'h040, 8'h01, 3'd0);
        mdl_idle = 1'b0; mdl_open = 1'b1; mdl_cancel = 1'b0; mdl_err = 1'b0;
    endtask

    initial begin
        int s0, i0, n, r;
        logic [11:0] off;
        logic [7:0] rd;
        logic ak;
        hif.host_addr = '0; hif.host_wr = 1'b0; hif.host_rd = 1'b0;
        hif.host_wdata = '0; hif.host_loc = '0;
        cmdOutAddr = '0; rspSize = '0; rspSend = 1'b1; rspOutAddr = '0;
        rspByteOut = '0; cmdDone = 1'b0; rspDone = 1'b0;

        cycles(3);
        chk("rst_locality", 32'(locality), 32'h0FF);
        chk("rst_abort", 32'(cmdAbort), 32'd0);
        chk("rst_cmdSize", cmdSize, 32'd0);
        chk("rst_send", 32'(cmdSend), 32'd0);
        chk("rst_cmdByteIn", 32'(cmdByteIn), 32'h0FF);
        chk("rst_rdata", 32'(hif.host_rdata), 32'd0);
        chk("rst_ack", 32'(hif.host_ack), 32'd0);
        chk("rst_irq", 32'(rsp_irq), 32'd0);
        reset_n = 1'b1;
        rdc("rst_sts", 13'h044, 3'd0, exp_reg(12'h044));
        rdc("rst_rsp_size", 13'h064, 3'd0, exp_reg(12'h064));

        wr(13'h008, 8'h01, 3'd0);
        mdl_owner = 0;
        chk("grant_loc0", 32'(locality), 32'd0);
        rdc("loc_state_0", 13'h000, 3'd0, exp_reg(12'h000));
        wr(13'h008, 8'h01, 3'd2);
        rdc("loc_state_held", 13'h000, 3'd2, exp_reg(12'h000));
        wr(13'h040, 8'h01, 3'd2);
        rdc("nonowner_ready", 13'h044, 3'd0, exp_reg(12'h044));
        cmd_ready_owner();
        rdc("sts_ready", 13'h044, 3'd0, exp_reg(12'h044));

        run_cmd(12, 10, 1'b0, 1'b1);

        cmd_ready_owner();
        n = $urandom_range(8, 40);
        r = $urandom_range(1, n - 1);
        run_cmd(n, r, 1'b1, 1'b0);
        cmd_ready_owner();
        rdc("cancel_cleared", 13'h048, 3'd0, exp_reg(12'h048));
        rdc("err_cleared", 13'h044, 3'd0, exp_reg(12'h044));

        // Oversize command: no engine start, straight to DONE with error.
        set_size(32'h1000);
        mdl_cmd_size = 32'h1000;
        chk("cmdSize_big", cmdSize, mdl_cmd_size);
        s0 = send_cnt; i0 = irq_cnt;
        wr(13'h04C, 8'h01, 3'd0);
        mdl_err = 1'b1; mdl_rsp_size = 32'd0;
        cycles(3);
        chk("big_no_send", 32'(send_cnt - s0), 32'd0);
        chk("big_irq", 32'(irq_cnt - i0), 32'd1);
        rdc("big_sts", 13'h044, 3'd0, exp_reg(12'h044));
        for (int j = 0; j < 4; j++) rdc("big_rsp_size", 13'h064 + 13'(j), 3'd0, exp_reg(12'h064 + 12'(j)));
        rdc("big_start", 13'h04C, 3'd0, exp_reg(12'h04C));
        rdbuf("big_buf", 0);
        wr(13'h058, 8'h55, 3'd0);
        chk("size_locked_done", cmdSize, mdl_cmd_size);
        wr(13'h008, 8'h02, 3'd0);
        chk("relinquish_done", 32'(locality), 32'd0);

        // Reset in the middle of response output.
        cmd_ready_owner();
        set_size(32'd4);
        wr(13'h04C, 8'h01, 3'd0);
        mdl_busy = 1'b1; mdl_open = 1'b0;
        cycles(2);
        eng_cmd_done();
        eng_rsp_byte(12'd0, 8'h5A);
        rdc("mid_busy", 13'h04C, 3'd0, exp_reg(12'h04C));
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_locality", 32'(locality), 32'h0FF);
        chk("mid_rst_cmdSize", cmdSize, 32'd0);
        chk("mid_rst_send", 32'(cmdSend), 32'd0);
        chk("mid_rst_cmdByteIn", 32'(cmdByteIn), 32'h0FF);
        chk("mid_rst_abort", 32'(cmdAbort), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        mdl_owner = -1; mdl_idle = 1'b1; mdl_open = 1'b0; mdl_busy = 1'b0;
        mdl_err = 1'b0; mdl_cancel = 1'b0; mdl_cmd_size = 32'd0; mdl_rsp_size = 32'd0;
        rdc("mid_rst_sts", 13'h044, 3'd0, exp_reg(12'h044));
        rdc("mid_rst_loc", 13'h000, 3'd0, exp_reg(12'h000));

        wr(13'h008, 8'h01, 3'd6);
        chk("loc6_denied", 32'(locality), 32'h0FF);
        wr(13'h008, 8'h01, 3'd4);
        mdl_owner = 4;
        chk("loc4_granted", 32'(locality), 32'd4);

        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 1) == 1) off = mapped[$urandom_range(0, 7)];
            else off = 12'($urandom_range(0, 127));
            rdc("reg_rand", {1'b0, off}, 3'($urandom_range(0, NUM_LOC - 1)), exp_reg(off));
        end

        bus(13'h008, 1'b1, 1'b1, 8'h02, 3'd4, rd, ak);
        mdl_owner = -1;
        chk("wr_rd_rdata", 32'(rd), 32'd0);
        chk("wr_rd_ack", 32'(ak), 32'd1);
        chk("wr_rd_relinquish", 32'(locality), 32'h0FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
